// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor:
// group width, propagate/generate pair type and stage-count helper.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int stages(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, carry-out and the
// group propagate/generate terms.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] bp;
  logic [3:0] bg;
  logic [3:0] c;
  pg_t        grp;

  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    c[0] = cin;
    c[1] = bg[0] | (bp[0] & cin);
    c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
    c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
         | (bp[2] & bp[1] & bp[0] & cin);
    grp.p = &bp;
    grp.g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
          | (bp[3] & bp[2] & bp[1] & bg[0]);
    s    = bp ^ c;
    cout = grp.g | (grp.p & cin);
    p    = grp.p;
    g    = grp.g;
  end

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Pipelined valid/ready subtractor, diff = in1 - in2 - bin, one lookahead
// group per stage. Define CLA_SUB_OVF_EN to add the registered signed-overflow output.
module cla_subtractor_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef CLA_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int STAGES = stages(WIDTH);
  localparam int L      = STAGES - 1;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_subtractor_pipe: WIDTH must be a multiple of 4 and >= 4");
  end

  // *_s: stage inputs, *_n: stage results, *_r: stage registers.
  // The borrow (inverted carry) is what travels, so reset zeros mean "no borrow".
  logic [WIDTH-1:0]   a_s  [STAGES];
  logic [WIDTH-1:0]   b_s  [STAGES];
  logic [WIDTH-1:0]   d_s  [STAGES];
  logic               br_s [STAGES];
  logic               v_s  [STAGES];
  logic [WIDTH-1:0]   d_n  [STAGES];
  logic               br_n [STAGES];
  logic [GROUP_W-1:0] s_g  [STAGES];
  pg_t                pg_g [STAGES];
  logic [STAGES-1:0]  co_g;
  logic [WIDTH-1:0]   a_r  [STAGES];
  logic [WIDTH-1:0]   b_r  [STAGES];
  logic [WIDTH-1:0]   d_r  [STAGES];
  logic               br_r [STAGES];
  logic               v_r  [STAGES];
  logic               en;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_r[L];
  assign diff      = d_r[L];
  assign bout      = br_r[L];

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    if (j == 0) begin : g_head
      assign a_s[j]  = in1;
      assign b_s[j]  = in2;
      assign d_s[j]  = '0;
      assign br_s[j] = bin;
      assign v_s[j]  = in_valid;
    end else begin : g_body
      assign a_s[j]  = a_r[j-1];
      assign b_s[j]  = b_r[j-1];
      assign d_s[j]  = d_r[j-1];
      assign br_s[j] = br_r[j-1];
      assign v_s[j]  = v_r[j-1];
    end

    cla_group4 u_grp (
      .a    (a_s[j][j*GROUP_W +: GROUP_W]),
      .b    (~b_s[j][j*GROUP_W +: GROUP_W]),
      .cin  (~br_s[j]),
      .s    (s_g[j]),
      .cout (co_g[j]),
      .p    (pg_g[j].p),
      .g    (pg_g[j].g)
    );
  end

  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      d_n[j]                       = d_s[j];
      d_n[j][j*GROUP_W +: GROUP_W] = s_g[j];
      br_n[j]                      = ~(pg_g[j].g | (pg_g[j].p & ~br_s[j]));
    end
  end

`ifdef CLA_SUB_OVF_EN
  logic ovf_n;
  logic ovf_r;

  assign ovf_n = (a_s[L][WIDTH-1] ^ b_s[L][WIDTH-1]) & (d_n[L][WIDTH-1] ^ a_s[L][WIDTH-1]);
  assign ovf   = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en) begin
      ovf_r <= ovf_n;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < STAGES; j++) begin
        v_r[j]  <= 1'b0;
        br_r[j] <= 1'b0;
        a_r[j]  <= '0;
        b_r[j]  <= '0;
        d_r[j]  <= '0;
      end
    end else if (en) begin
      for (int j = 0; j < STAGES; j++) begin
        v_r[j]  <= v_s[j];
        br_r[j] <= br_n[j];
        a_r[j]  <= a_s[j];
        b_r[j]  <= b_s[j];
        d_r[j]  <= d_n[j];
      end
    end
  end

  // The group carry-out duplicates br_n, and the last stage's operand copies have no consumer.
  logic unused_bits;
  assign unused_bits = ^{co_g, a_r[L], b_r[L]};

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Directed-vector bench for cla_subtractor_pipe (WIDTH=16) with a scoreboard
// of hand-computed results; covers ovf when CLA_SUB_OVF_EN is defined.
module tb_cla_subtractor_pipe;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
`ifdef CLA_SUB_OVF_EN
  logic        ovf;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rx    = 0;
  int   cyc     = 0;
  exp_t drv_exp;
  exp_t exp_q [$];
  int   rx_cyc [$];

  cla_subtractor_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef CLA_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: transfers are decided by the values held between negedge and the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          check("diff", {16'd0, diff}, {16'd0, exp_q[0].d});
          check("bout", {31'd0, bout}, {31'd0, exp_q[0].bo});
`ifdef CLA_SUB_OVF_EN
          check("ovf", {31'd0, ovf}, {31'd0, exp_q[0].ov});
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            rx_cyc.push_back(cyc);
            n_rx++;
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [15:0] d, input logic bo, input logic ov);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    in1 = a; in2 = b; bin = bi;
    drv_exp = '{d: d, bo: bo, ov: ov};
    in_valid = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 64) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 64) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; bin = 1'b0;
    out_ready = 1'b1; drv_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CLA_SUB_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: acceptance edge is edge 1, result register loads on edge 4
    send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency_edges", cnt, 32'd4);
    wait_drain();

    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send(16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0);
    wait_drain();

    // back-to-back stream
    rx_cyc.delete();
    send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
    send(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    wait_drain();
    check("b2b_count", rx_cyc.size(), 32'd8);
    if (rx_cyc.size() == 8) check("b2b_span", rx_cyc[7] - rx_cyc[0], 32'd7);

    // fill, stall three cycles, release
    base = n_rx;
    send(16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0);
    send(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in1 = 16'hDEAD; in2 = 16'hBEEF; bin = 1'b0;
    drv_exp = '{d: 16'h1FBE, bo: 1'b0, ov: 1'b0};
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("stall_results", n_rx - base, 32'd4);

    // reset with results in flight
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0);
    send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0);
    send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_diff", {16'd0, diff}, 32'd0);
    check("mid_reset_bout", {31'd0, bout}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_rx;
    send(16'h4444, 16'h0004, 1'b1, 16'h443F, 1'b0, 1'b0);
    wait_drain();
    check("post_reset_results", n_rx - base, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
